// File: rtl/sha_1_padder.sv
// rtl/sha_1_padder.sv - SHA-1 message padder: byte stream in, padded 512-bit blocks out as 16 big-endian words.
module sha_1_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  input  logic        in_keep,
  output logic [31:0] block_data [15:0],
  output logic        block_valid,
  input  logic        block_ready,
  output logic        block_last,
  output logic        busy
);

  typedef enum logic [1:0] {FILL, PAD, LENBLK, EMIT} state_t;

  state_t           state_q, state_d;
  logic [511:0]     buf_q, buf_d;
  logic [6:0]       idx_q, idx_d;
  logic [LEN_W-4:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             pend_len_q, pend_len_d;
  logic             pend80_q, pend80_d;
  logic             busy_q, busy_d;
  logic [63:0]      len64;
  logic [8:0]       wr_lsb;
  logic             accept;

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = {cnt_q, 3'b000};
  end

  // Byte 0 lives in the top bits of the buffer so words come out big-endian.
  assign wr_lsb = {6'd63 - idx_q[5:0], 3'b000};
  assign accept = in_valid && (state_q == FILL);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    pend_len_d = pend_len_q;
    pend80_d   = pend80_q;
    busy_d     = busy_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          busy_d = 1'b1;
          if (in_keep) begin
            buf_d[wr_lsb +: 8] = in_byte;
            idx_d = idx_q + 7'd1;
            cnt_d = cnt_q + (LEN_W-3)'(1);
          end
          if (in_last) begin
            state_d = PAD;
          end else if (in_keep && idx_q == 7'd63) begin
            state_d    = EMIT;
            last_d     = 1'b0;
            pend_len_d = 1'b0;
          end
        end
      end
      PAD: begin
        state_d  = EMIT;
        pend80_d = 1'b0;
        if (idx_q <= 7'd55) begin
          buf_d[wr_lsb +: 8] = 8'h80;
          buf_d[63:0]        = len64;
          last_d             = 1'b1;
          pend_len_d         = 1'b0;
        end else begin
          // A full buffer defers the 0x80 marker to byte 0 of the length block.
          if (!idx_q[6]) buf_d[wr_lsb +: 8] = 8'h80;
          else           pend80_d = 1'b1;
          last_d     = 1'b0;
          pend_len_d = 1'b1;
        end
      end
      LENBLK: begin
        buf_d[63:0] = len64;
        if (pend80_q) buf_d[511:504] = 8'h80;
        last_d     = 1'b1;
        pend_len_d = 1'b0;
        pend80_d   = 1'b0;
        state_d    = EMIT;
      end
      EMIT: begin
        if (block_ready) begin
          buf_d = '0;
          idx_d = '0;
          if (last_q) begin
            state_d = FILL;
            cnt_d   = '0;
            busy_d  = 1'b0;
          end else if (pend_len_q) begin
            state_d = LENBLK;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      buf_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      pend_len_q <= 1'b0;
      pend80_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      pend_len_q <= pend_len_d;
      pend80_q   <= pend80_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready    = (state_q == FILL);
  assign block_valid = (state_q == EMIT);
  assign block_last  = (state_q == EMIT) && last_q;
  assign busy        = busy_q;

  for (genvar k = 0; k < 16; k++) begin : g_words
    assign block_data[k] = buf_q[511-32*k -: 32];
  end

endmodule

// File: tb/tb_sha_1_padder.sv
// tb/tb_sha_1_padder.sv - directed vector bench for sha_1_padder.
module tb_sha_1_padder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_keep;
  logic [31:0] block_data [15:0];
  logic        block_valid;
  logic        block_ready;
  logic        block_last;
  logic        busy;

  always #5 clk = ~clk;

  sha_1_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_last(in_last), .in_keep(in_keep),
    .block_data(block_data), .block_valid(block_valid), .block_ready(block_ready),
    .block_last(block_last), .busy(busy)
  );

  typedef struct {
    int           len;
    logic [7:0]   fill;
    bit           incr;
    bit           tail;
    int           nblk;
    logic [511:0] e0;
    logic         l0;
    logic [511:0] e1;
    logic         l1;
  } vec_t;

  vec_t v [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [511:0] blk(int lo, int hi, logic [31:0] w);
    logic [511:0] r;
    r = '0;
    for (int k = lo; k <= hi; k++) r[511-32*k -: 32] = w;
    return r;
  endfunction

  function automatic logic [511:0] cur_blk();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[511-32*k -: 32] = block_data[k];
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic set_vec(input int i, input int len, input logic [7:0] fill, input bit incr,
                         input bit tail, input int nblk, input logic [511:0] e0, input logic l0,
                         input logic [511:0] e1, input logic l1);
    v[i].len = len;   v[i].fill = fill; v[i].incr = incr; v[i].tail = tail;
    v[i].nblk = nblk; v[i].e0 = e0;     v[i].l0 = l0;     v[i].e1 = e1; v[i].l1 = l1;
  endtask

  task automatic run_vec(input int vi);
    vec_t t;
    int   total;
    t = v[vi];
    total = t.len + (t.tail ? 1 : 0);
    fork
      begin : drv
        int i;
        int g;
        i = 0;
        g = 0;
        while (i < total && g < 4000) begin
          @(negedge clk);
          g++;
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
          end else begin
            in_valid = 1'b1;
            in_keep  = (i < t.len);
            in_last  = (i == total - 1);
            in_byte  = (i < t.len) ? t.fill + (t.incr ? 8'(i) : 8'd0) : 8'hFF;
            if (in_ready) i++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_keep  = 1'b0;
        if (i < total) begin
          n_cmp++;
          n_bad++;
          $display("FAIL vec%0d drive timeout: sent %0d want %0d", vi, i, total);
        end
      end
      begin : col
        int b;
        int g;
        b = 0;
        g = 0;
        while (b < t.nblk && g < 4000) begin
          @(negedge clk);
          g++;
          block_ready = ($urandom_range(0, 2) != 0);
          if (block_valid && block_ready) begin
            chk($sformatf("vec%0d blk%0d data", vi, b), cur_blk(), (b == 0) ? t.e0 : t.e1);
            chk1($sformatf("vec%0d blk%0d last", vi, b), 32'(block_last), 32'((b == 0) ? t.l0 : t.l1));
            b++;
          end
        end
        @(negedge clk);
        block_ready = 1'b0;
        if (b < t.nblk) begin
          n_cmp++;
          n_bad++;
          $display("FAIL vec%0d block timeout: got %0d blocks want %0d", vi, b, t.nblk);
        end
      end
    join
    chk1($sformatf("vec%0d idle busy", vi), 32'(busy), 32'd0);
    chk1($sformatf("vec%0d idle valid", vi), 32'(block_valid), 32'd0);
  endtask

  task automatic wait_blk(input string name, input logic [511:0] exp, input logic expl);
    bit seen;
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge clk);
      block_ready = 1'b1;
      if (block_valid) begin
        chk({name, " data"}, cur_blk(), exp);
        chk1({name, " last"}, 32'(block_last), 32'(expl));
        seen = 1'b1;
      end
    end
    @(negedge clk);
    block_ready = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no block want one", name);
    end
  endtask

  logic [511:0] abc_blk;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0; in_keep = 1'b0; block_ready = 1'b0;
    abc_blk = blk(0, 0, 32'h61626380) | blk(15, 15, 32'h00000018);
    set_vec(0, 3,   8'h61, 1, 0, 1, abc_blk, 1, '0, 0);
    set_vec(1, 0,   8'h00, 0, 1, 1, blk(0, 0, 32'h80000000), 1, '0, 0);
    set_vec(2, 55,  8'h00, 0, 0, 1, blk(13, 13, 32'h00000080) | blk(15, 15, 32'h000001B8), 1, '0, 0);
    set_vec(3, 56,  8'h61, 0, 0, 2, blk(0, 13, 32'h61616161) | blk(14, 14, 32'h80000000), 0,
            blk(15, 15, 32'h000001C0), 1);
    set_vec(4, 64,  8'h61, 0, 0, 2, blk(0, 15, 32'h61616161), 0,
            blk(0, 0, 32'h80000000) | blk(15, 15, 32'h00000200), 1);
    set_vec(5, 3,   8'h61, 1, 1, 1, abc_blk, 1, '0, 0);
    set_vec(6, 63,  8'h11, 0, 0, 2, blk(0, 14, 32'h11111111) | blk(15, 15, 32'h11111180), 0,
            blk(15, 15, 32'h000001F8), 1);
    set_vec(7, 100, 8'h22, 0, 0, 2, blk(0, 15, 32'h22222222), 0,
            blk(0, 8, 32'h22222222) | blk(9, 9, 32'h80000000) | blk(15, 15, 32'h00000320), 1);
    set_vec(8, 64,  8'h61, 0, 1, 2, blk(0, 15, 32'h61616161), 0,
            blk(0, 0, 32'h80000000) | blk(15, 15, 32'h00000200), 1);

    repeat (3) @(negedge clk);
    chk1("rst in_ready", 32'(in_ready), 32'd1);
    chk1("rst block_valid", 32'(block_valid), 32'd0);
    chk1("rst block_last", 32'(block_last), 32'd0);
    chk1("rst busy", 32'(busy), 32'd0);
    chk("rst data", cur_blk(), '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int vi = 0; vi < 9; vi++) run_vec(vi);

    // "abc" back to back: latency to block_valid, then downstream stall with input offered
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_keep = 1'b1; in_byte = 8'h61 + 8'(i); in_last = (i == 2);
    end
    @(negedge clk);
    in_byte = 8'h55; in_last = 1'b0;
    chk1("lat t+1 valid", 32'(block_valid), 32'd0);
    chk1("lat t+1 in_ready", 32'(in_ready), 32'd0);
    chk1("lat t+1 busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk1("lat t+2 valid", 32'(block_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall c%0d data", c), cur_blk(), abc_blk);
      chk1($sformatf("stall c%0d flags", c), {29'd0, block_valid, block_last, in_ready}, 32'b110);
    end
    in_valid = 1'b0;
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    chk1("post take flags", {29'd0, block_valid, busy, in_ready}, 32'b001);
    chk("post take data", cur_blk(), '0);

    // 64 bytes without gaps: full block visible one cycle after the 64th byte
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_keep = 1'b1; in_byte = 8'h61; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk1("full t+1 valid", 32'(block_valid), 32'd1);
    chk1("full t+1 last", 32'(block_last), 32'd0);
    chk("full t+1 data", cur_blk(), v[4].e0);
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    in_valid = 1'b1; in_keep = 1'b0; in_last = 1'b1; in_byte = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_blk("full tail blk", v[4].e1, 1'b1);

    // reset in the middle of a 40-byte message, then a fresh "abc"
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_keep = 1'b1; in_byte = 8'h33; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("midrst flags", {28'd0, in_ready, block_valid, block_last, busy}, 32'b1000);
    chk("midrst data", cur_blk(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
